// File: rtl/rom_arb_pkg.sv
// rom_arb_pkg: shared types and image geometry for the ROM arbiter slice.
//   owner_e  - owner of a ROM read slot (IDLE / DISP / AUX)
//   tag_t    - per-slot tag carried down the read pipeline
//   IMG_W, IMG_H, ADDR_W - default QVGA image geometry
package rom_arb_pkg;

    localparam int IMG_W  = 320;
    localparam int IMG_H  = 240;
    localparam int ADDR_W = 17;

    typedef enum logic [1:0] {
        IDLE,
        DISP,
        AUX
    } owner_e;

    typedef struct packed {
        logic   valid;
        owner_e owner;
        logic   oor;
    } tag_t;

    localparam tag_t TAG_NONE = '{valid: 1'b0, owner: IDLE, oor: 1'b0};

endpackage

// File: rtl/rom_arbiter_qvga_addr_gen.sv
// qvga_addr_gen: QVGA x/y to linear ROM address (y*320 + x) with range flag.
//   x, y      in  10-bit pixel coordinates
//   addr      out ADDR_W linear address, y*256 + y*64 + x
//   in_range  out x < IMG_W and y < IMG_H
module qvga_addr_gen
    import rom_arb_pkg::*;
#(
    parameter int IMG_W  = rom_arb_pkg::IMG_W,
    parameter int IMG_H  = rom_arb_pkg::IMG_H,
    parameter int ADDR_W = rom_arb_pkg::ADDR_W
) (
    input  logic [9:0]        x,
    input  logic [9:0]        y,
    output logic [ADDR_W-1:0] addr,
    output logic              in_range
);

    // 320 = 256 + 64, so the multiply collapses to two shifts and an add
    assign addr     = (ADDR_W'(y) << 8) + (ADDR_W'(y) << 6) + ADDR_W'(x);
    assign in_range = (x < 10'(IMG_W)) && (y < 10'(IMG_H));

endmodule

// File: rtl/rom_arbiter.sv
// rom_arbiter: shares a registered-read image ROM between the VGA display path
// (priority, fixed latency) and an auxiliary req/gnt port; both see 3-cycle latency.
//   clk, reset_n                  clock, asynchronous active-low reset
//   disp_req, disp_x, disp_y      display request with QVGA coordinates
//   disp_valid, disp_data         display return pulse and pixel
//   disp_miss                     display slot lost to a forced aux grant
//   aux_req, aux_addr, aux_gnt    aux request, linear address, combinational grant
//   aux_rvalid, aux_rdata         aux return pulse and data
//   rom_addr, rom_data            registered ROM address / registered ROM data
// Optional build macro ROM_ARB_STARVE_GUARD_EN: forces an aux grant after
// STARVE_MAX consecutive lost slots; without it display priority is strict.
module rom_arbiter
    import rom_arb_pkg::*;
#(
    parameter int IMG_W  = rom_arb_pkg::IMG_W,
    parameter int IMG_H  = rom_arb_pkg::IMG_H,
    parameter int ADDR_W = rom_arb_pkg::ADDR_W,
    parameter int DATA_W = 16
`ifdef ROM_ARB_STARVE_GUARD_EN
    ,
    parameter int STARVE_MAX = 64
`endif
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              disp_req,
    input  logic [9:0]        disp_x,
    input  logic [9:0]        disp_y,
    output logic              disp_valid,
    output logic [DATA_W-1:0] disp_data,
    output logic              disp_miss,
    input  logic              aux_req,
    input  logic [ADDR_W-1:0] aux_addr,
    output logic              aux_gnt,
    output logic              aux_rvalid,
    output logic [DATA_W-1:0] aux_rdata,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data
);

    localparam int PIX = IMG_W * IMG_H;

    logic [ADDR_W-1:0] disp_addr;
    logic [ADDR_W-1:0] rom_addr_next;
    logic              in_range;
    logic              disp_hit;
    logic              aux_oor;
    logic              force_aux;
    owner_e            state;
    owner_e            next_state;
    logic              d_valid1;
    logic              d_oor1;
    logic              a_valid1;
    logic              a_oor1;
    tag_t              dt1;
    tag_t              at1;
    tag_t              dt2;
    tag_t              at2;

    qvga_addr_gen #(
        .IMG_W (IMG_W),
        .IMG_H (IMG_H),
        .ADDR_W(ADDR_W)
    ) u_addr_gen (
        .x       (disp_x),
        .y       (disp_y),
        .addr    (disp_addr),
        .in_range(in_range)
    );

    assign disp_hit = disp_req && in_range;
    assign aux_oor  = aux_addr >= ADDR_W'(PIX);

`ifdef ROM_ARB_STARVE_GUARD_EN
    localparam int CNT_W = $clog2(STARVE_MAX + 1);

    logic [CNT_W-1:0] starve_cnt;

    // aux pending without a grant can only mean the display took the slot,
    // so the counter needs no separate display qualifier
    assign force_aux = aux_req && (starve_cnt == CNT_W'(STARVE_MAX));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            starve_cnt <= '0;
        else
            starve_cnt <= (aux_gnt || !aux_req) ? '0 : starve_cnt + 1'b1;
    end
`else
    assign force_aux = 1'b0;
`endif

    assign aux_gnt = aux_req && (!disp_hit || force_aux);

    // owner FSM: state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            state <= IDLE;
        else
            state <= next_state;
    end

    // owner FSM: next state straight from this cycle's arbitration
    always_comb begin
        next_state = (disp_hit && !force_aux) ? DISP : aux_gnt ? AUX : IDLE;
    end

    // owner FSM: address for the slot; an out-of-range aux grant reads nothing
    always_comb begin
        rom_addr_next = (next_state == DISP)             ? disp_addr :
                        (next_state == AUX && !aux_oor)  ? aux_addr  : rom_addr;
    end

    // stage 1 takes its owner from the FSM register, so only the flags are stored here
    assign dt1 = '{valid: d_valid1, owner: state, oor: d_oor1};
    assign at1 = '{valid: a_valid1, owner: state, oor: a_oor1};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rom_addr <= '0;
            d_valid1 <= 1'b0;
            d_oor1   <= 1'b0;
            a_valid1 <= 1'b0;
            a_oor1   <= 1'b0;
            dt2      <= TAG_NONE;
            at2      <= TAG_NONE;
        end else begin
            rom_addr <= rom_addr_next;
            d_valid1 <= disp_req;
            d_oor1   <= !in_range;
            a_valid1 <= aux_gnt;
            a_oor1   <= aux_oor;
            dt2      <= dt1;
            at2      <= at1;
        end
    end

    // a display return carries ROM data only if the display owned its slot
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            disp_valid <= 1'b0;
            disp_data  <= '0;
            aux_rvalid <= 1'b0;
            aux_rdata  <= '0;
        end else begin
            disp_valid <= dt2.valid;
            aux_rvalid <= at2.valid;
            if (dt2.valid)
                disp_data <= (dt2.owner == DISP && !dt2.oor) ? rom_data : '0;
            if (at2.valid)
                aux_rdata <= (at2.owner == AUX && !at2.oor) ? rom_data : '0;
        end
    end

`ifdef ROM_ARB_STARVE_GUARD_EN
    // an in-range display request whose slot went to aux is a miss
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            disp_miss <= 1'b0;
        else
            disp_miss <= dt2.valid && dt2.owner == AUX && !dt2.oor;
    end
`else
    assign disp_miss = 1'b0;
`endif

endmodule

// File: tb/tb_rom_arbiter.sv
// tb_rom_arbiter: table-driven and scoreboarded bench for rom_arbiter.
module tb_rom_arbiter;

`ifdef ROM_ARB_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n;
    logic        disp_req;
    logic [9:0]  disp_x;
    logic [9:0]  disp_y;
    logic        disp_valid;
    logic [15:0] disp_data;
    logic        disp_miss;
    logic        aux_req;
    logic [16:0] aux_addr;
    logic        aux_gnt;
    logic        aux_rvalid;
    logic [15:0] aux_rdata;
    logic [16:0] rom_addr;
    logic [15:0] rom_data = '0;

    rom_arbiter dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .disp_req  (disp_req),
        .disp_x    (disp_x),
        .disp_y    (disp_y),
        .disp_valid(disp_valid),
        .disp_data (disp_data),
        .disp_miss (disp_miss),
        .aux_req   (aux_req),
        .aux_addr  (aux_addr),
        .aux_gnt   (aux_gnt),
        .aux_rvalid(aux_rvalid),
        .aux_rdata (aux_rdata),
        .rom_addr  (rom_addr),
        .rom_data  (rom_data)
    );

    always #5 clk = ~clk;

    // ROM image mem[i] = i[15:0] with a one-cycle registered read
    always @(posedge clk) rom_data <= rom_addr[15:0];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int due;
        int data;
        bit miss;
    } exp_t;

    typedef struct {
        bit dr;
        int x;
        int y;
        bit ar;
        int aa;
        bit gnt;
        int dd;
        int ad;
        int rom;
    } vec_t;

    exp_t dq[$];
    exp_t aq[$];
    vec_t vt[12];
    int   n_cmp = 0;
    int   n_fail = 0;
    int   exp_rom = 0;
    int   last_dd = 0;
    int   last_ad = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", nm, cyc, act, exp);
        end
    endtask

    task automatic check_outputs();
        exp_t e;
        bit   dv;
        bit   av;
        dv = dq.size() > 0 && dq[0].due == cyc;
        av = aq.size() > 0 && aq[0].due == cyc;
        chk("disp_valid", int'(disp_valid), int'(dv));
        chk("aux_rvalid", int'(aux_rvalid), int'(av));
        if (dv) begin
            e = dq.pop_front();
            last_dd = e.data;
            chk("disp_miss", int'(disp_miss), int'(e.miss));
        end else
            chk("disp_miss_idle", int'(disp_miss), 0);
        if (av) begin
            e = aq.pop_front();
            last_ad = e.data;
        end
        chk("disp_data", int'(disp_data), last_dd);
        chk("aux_rdata", int'(aux_rdata), last_ad);
        chk("rom_addr", int'(rom_addr), exp_rom);
    endtask

    // one clock of stimulus: drive, check at the falling edge, queue expectations
    task automatic cycle(input bit dr, input int x, input int y, input bit ar, input int aa,
                         input bit e_gnt, input int e_dd, input bit e_miss, input int e_ad,
                         input int e_rom);
        disp_req = dr;
        disp_x   = 10'(x);
        disp_y   = 10'(y);
        aux_req  = ar;
        aux_addr = 17'(aa);
        @(negedge clk);
        check_outputs();
        chk("aux_gnt", int'(aux_gnt), int'(e_gnt));
        if (dr) dq.push_back('{cyc + 3, e_dd, e_miss});
        if (e_gnt) aq.push_back('{cyc + 3, e_ad, 1'b0});
        @(posedge clk);
        #1;
        exp_rom = e_rom;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 0, 0, 1'b0, 0, 1'b0, 0, 1'b0, 0, exp_rom);
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_rom_addr"}, int'(rom_addr), 0);
        chk({tag, "_disp_valid"}, int'(disp_valid), 0);
        chk({tag, "_disp_data"}, int'(disp_data), 0);
        chk({tag, "_disp_miss"}, int'(disp_miss), 0);
        chk({tag, "_aux_rvalid"}, int'(aux_rvalid), 0);
        chk({tag, "_aux_rdata"}, int'(aux_rdata), 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL timeout at cycle %0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        int a;
        bit g;
        //        dr    x     y     ar    aa      gnt   dd     ad  rom
        vt[0]  = '{1'b1, 5,    2,    1'b0, 0,      1'b0, 645,   0,  645};
        vt[1]  = '{1'b1, 0,    0,    1'b1, 100,    1'b0, 0,     0,  0};
        vt[2]  = '{1'b0, 0,    0,    1'b1, 100,    1'b1, 0,     100, 100};
        vt[3]  = '{1'b1, 320,  0,    1'b1, 7,      1'b1, 0,     7,  7};
        vt[4]  = '{1'b1, 319,  239,  1'b0, 0,      1'b0, 11263, 0,  76799};
        vt[5]  = '{1'b0, 0,    0,    1'b1, 76800,  1'b1, 0,     0,  76799};
        vt[6]  = '{1'b1, 0,    240,  1'b0, 0,      1'b0, 0,     0,  76799};
        vt[7]  = '{1'b0, 0,    0,    1'b0, 0,      1'b0, 0,     0,  76799};
        vt[8]  = '{1'b1, 100,  100,  1'b1, 65539,  1'b0, 32100, 0,  32100};
        vt[9]  = '{1'b1, 1023, 1023, 1'b1, 65539,  1'b1, 0,     3,  65539};
        vt[10] = '{1'b0, 0,    0,    1'b1, 131071, 1'b1, 0,     0,  65539};
        vt[11] = '{1'b1, 319,  0,    1'b0, 0,      1'b0, 319,   0,  319};

        reset_n  = 1'b0;
        disp_req = 1'b0;
        disp_x   = '0;
        disp_y   = '0;
        aux_req  = 1'b0;
        aux_addr = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_zero_outputs("reset");
        chk("reset_aux_gnt", int'(aux_gnt), 0);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 12; i++)
            cycle(vt[i].dr, vt[i].x, vt[i].y, vt[i].ar, vt[i].aa,
                  vt[i].gnt, vt[i].dd, 1'b0, vt[i].ad, vt[i].rom);
        idle(4);

        // full frame stream, one pixel per cycle
        for (int y = 0; y < 240; y++)
            for (int x = 0; x < 320; x++) begin
                a = y * 320 + x;
                cycle(1'b1, x, y, 1'b0, 0, 1'b0, a & 16'hffff, 1'b0, 0, a);
            end
        idle(4);

        // display and aux both held continuously
        for (int i = 0; i < 130; i++) begin
            g = GUARD && (i % 65 == 64);
            cycle(1'b1, 1, 0, 1'b1, 9, g, g ? 0 : 1, g, 9, g ? 9 : 1);
        end
        idle(4);

        // reset with reads in flight
        for (int i = 0; i < 4; i++)
            cycle(1'b0, 0, 0, 1'b1, 200 + i, 1'b1, 0, 1'b0, 200 + i, 200 + i);
        aux_req = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        chk_zero_outputs("async_rst");
        dq.delete();
        aq.delete();
        exp_rom = 0;
        last_dd = 0;
        last_ad = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        idle(6);
        cycle(1'b0, 0, 0, 1'b1, 42, 1'b1, 0, 1'b0, 42, 42);
        cycle(1'b1, 7, 1, 1'b0, 0, 1'b0, 327, 1'b0, 0, 327);
        idle(5);
        chk("drain", dq.size() + aq.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/rom_arbiter.md
Name: rom_arbiter

Overview:
- Shares the single-port, registered-read image ROM (320x240 pixels, 16-bit RGB565, 1-cycle BRAM read) between two requesters.
- Requester 1 is the VGA display path. It has priority, gives QVGA x/y coordinates, and receives data at a fixed latency.
- Requester 2 is an auxiliary port (e.g. UART image dump or filter engine). It gives a linear address and uses a req/gnt handshake.
- Sits between the VGA timing/scaler logic and the ROM. Owns the rom_addr register and tags every in-flight read so returned data is routed to the requester that issued it.

Parameters:
- IMG_W, 320, image width in pixels
- IMG_H, 240, image height in lines
- ADDR_W, 17, ROM address width, equal to $clog2(IMG_W*IMG_H)
- DATA_W, 16, pixel width
- STARVE_MAX, 64, consecutive display grants tolerated while aux is pending (used only with the optional feature)

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- disp_req  in  1  display pixel request, sampled every cycle
- disp_x  in  10  QVGA x coordinate
- disp_y  in  10  QVGA y coordinate
- disp_valid  out  1  display data valid, exactly 3 cycles after the request
- disp_data  out  DATA_W  display pixel
- disp_miss  out  1  qualifies disp_valid: slot was lost to aux, data forced to 0
- aux_req  in  1  aux request; held with aux_addr until aux_gnt
- aux_addr  in  ADDR_W  aux linear address
- aux_gnt  out  1  combinational; request accepted this cycle
- aux_rvalid  out  1  aux data valid, 3 cycles after the gnt cycle
- aux_rdata  out  DATA_W  aux data
- rom_addr  out  ADDR_W  registered address to ROM
- rom_data  in  DATA_W  ROM registered read data

Behaviour:
- Reset (async assert, sync release):
  - rom_addr, disp_valid, disp_data, disp_miss, aux_rvalid and aux_rdata are all 0.
  - Tag pipeline is cleared, owner state is IDLE.
  - Reads in flight when reset asserts are dropped; no valid is produced for them after release.
- Address generation (cycle N):
  - addr = (y<<8) + (y<<6) + x, computed at ADDR_W width with no truncation for in-range coordinates.
  - in_range = (x < IMG_W) && (y < IMG_H).
- Arbitration (cycle N, combinational):
  - Display request that is in range wins the slot.
  - Out-of-range display request consumes no ROM slot. Aux may take that slot. The display request still returns disp_valid=1 with data 0 at the normal latency.
  - aux_gnt = aux_req && !(disp_req && in_range), except when forced by the optional feature.
  - Simultaneous requests: display wins; aux keeps waiting.
- Owner FSM (registered at N+1 edge):
  - States are IDLE, DISP, AUX, giving the owner of the slot issued in cycle N.
  - Transitions follow the arbitration result each cycle; any state can go to any other.
  - IDLE keeps rom_addr at its previous value.
- Pipeline:
  - N+1 edge: rom_addr registered. Tag {valid, owner, oor} enters stage 1.
  - N+2 edge: ROM registers data. Tag moves to stage 2.
  - N+3 edge: output registers load from rom_data according to the stage-2 tag.
  - Latency is therefore 3 cycles for both ports.
- Throughput: one request per cycle sustained, back-to-back grants allowed.
- Output pulses: disp_valid and aux_rvalid are 1-cycle pulses. When not valid, the data outputs hold their last value.
- aux_addr >= IMG_W*IMG_H: the request is granted and aux_rdata = 0. No ROM read is issued.

Optional Feature:
- Macro: ROM_ARB_STARVE_GUARD_EN.
- With the macro:
  - A counter counts consecutive cycles where aux_req=1 and the display took the slot.
  - When the counter reaches STARVE_MAX, the next cycle grants aux regardless of the display request.
  - The display request in that cycle returns disp_valid=1, disp_miss=1, disp_data=0 at latency 3.
  - The counter clears on any aux_gnt or when aux_req=0.
- Without the macro: strict display priority; disp_miss is tied to 0.

Decomposition:
- Package rom_arb_pkg holds:
  - owner_e enum: IDLE, DISP, AUX.
  - Tag struct: valid, owner_e, oor.
  - IMG_W, IMG_H and ADDR_W defaults.
- Sub-module qvga_addr_gen: combinational shift-add address plus in_range flag, reused by future scaler blocks.

Test Plan:
- Preload ROM with mem[i]=i[15:0]. Display request (x=5, y=2) at cycle 10 -> rom_addr=645 at cycle 11; disp_valid=1, disp_data=16'h0285 at cycle 13.
- disp_req and aux_req (addr 100) asserted at the same cycle, display in range -> aux_gnt=0. Drop disp_req next cycle -> aux_gnt=1; aux_rvalid=1 with data 16'h0064 exactly 3 cycles after the gnt cycle.
- disp_x=320, y=0 while aux_req addr=7 -> aux_gnt=1 in the same cycle. After 3 cycles: disp_valid=1 with data 0, and aux_rvalid=1 with data 16'h0007.
- Stream 76800 consecutive display requests covering the full frame -> every pixel returned in order, no bubbles; final pixel (319,239) reads address 76799.
- Assert reset_n=0 with 2 reads in flight -> all outputs 0 immediately. After release, no valid pulses until a new request is issued.
- With ROM_ARB_STARVE_GUARD_EN: continuous disp_req and aux_req -> aux_gnt=1 on the 65th cycle. That slot returns disp_miss=1 with data 0, and the counter restarts.
